// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: latches button presses, grants one per cycle round-robin into a FWFT event FIFO.
// Optional feature: define BTN_EVT_DROP_CNT_EN to add a saturating 8-bit drop_count output.
module btn_event_arbiter #(
  parameter int NBTN = 4,
  parameter int DEPTH = 4,
  localparam int IDW = $clog2(NBTN),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_pulse,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [IDW-1:0]  evt_id,
  output logic [NBTN-1:0] pending,
  output logic [CW-1:0]   fifo_count,
  output logic            overflow
`ifdef BTN_EVT_DROP_CNT_EN
  ,
  output logic [7:0]      drop_count
`endif
);
  logic [IDW-1:0] mem [DEPTH];
  logic [IDW-1:0] rr_ptr, gnt_idx;
  logic [AW-1:0] wptr, rptr;
  logic [NBTN-1:0] gnt_vec, drop;
  logic gnt, pop;
  // Scan downward from the farthest offset so the index nearest rr_ptr wins.
  always_comb begin
    gnt_idx = '0;
    for (int k = NBTN - 1; k >= 0; k--)
      if (pending[(int'(rr_ptr) + k) % NBTN]) gnt_idx = IDW'((int'(rr_ptr) + k) % NBTN);
    gnt = (|pending) && (fifo_count != CW'(DEPTH));
    gnt_vec = gnt ? (NBTN'(1) << gnt_idx) : '0;
    drop = btn_pulse & pending & ~gnt_vec;
    pop = evt_valid & evt_ready;
  end
  assign evt_valid = fifo_count != '0;
  assign evt_id = mem[rptr];
  always_ff @(posedge clk)
    if (gnt && !rst) mem[wptr] <= gnt_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      rr_ptr <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~gnt_vec) | btn_pulse;
      overflow <= overflow | (|drop);
      if (gnt) begin
        wptr <= wptr + 1'b1;
        rr_ptr <= (gnt_idx == IDW'(NBTN - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      fifo_count <= fifo_count + CW'(gnt) - CW'(pop);
    end
  end
`ifdef BTN_EVT_DROP_CNT_EN
  logic [3:0] ndrop;
  logic [8:0] dsum;
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NBTN; i++) ndrop = ndrop + 4'(drop[i]);
    dsum = {1'b0, drop_count} + 9'(ndrop);
  end
  always_ff @(posedge clk)
    drop_count <= rst ? 8'd0 : (dsum > 9'd255 ? 8'hff : dsum[7:0]);
`endif
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: queue-based reference model with a decoupled pop-order scoreboard.
module tb_btn_event_arbiter;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] btn_pulse = '0;
  logic evt_ready = 0;
  logic evt_valid;
  logic [1:0] evt_id;
  logic [N-1:0] pending;
  logic [2:0] fifo_count;
  logic overflow;
`ifdef BTN_EVT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  int checks = 0;
  int failures = 0;
  bit m_pend [N];
  int m_rr;
  int m_q [$];
  int exp_q [$];
  bit m_ovf;
  int m_drop;
  int e;

  always #5 clk = ~clk;

  btn_event_arbiter #(.NBTN(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .pending(pending),
    .fifo_count(fifo_count), .overflow(overflow)
`ifdef BTN_EVT_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending set per button, oldest-first event queue, round-robin pick.
  task automatic model(logic [N-1:0] p, bit rdy, bit r);
    int g;
    bit do_pop;
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_rr = 0;
      m_q.delete();
      exp_q.delete();
      m_ovf = 0;
      m_drop = 0;
      return;
    end
    g = -1;
    if (m_q.size() < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    do_pop = rdy && m_q.size() > 0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && m_pend[i] && i != g) begin
        m_ovf = 1;
        m_drop = m_drop < 255 ? m_drop + 1 : 255;
      end
      m_pend[i] = (m_pend[i] && i != g) || p[i];
    end
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      exp_q.push_back(g);
      m_rr = (g + 1) % N;
    end
  endtask

  task automatic cyc(logic [N-1:0] p, bit rdy, bit r);
    logic [N-1:0] mp;
    btn_pulse = p;
    evt_ready = rdy;
    rst = r;
    model(p, rdy, r);
    @(posedge clk);
    #1;
    foreach (m_pend[i]) mp[i] = m_pend[i];
    chk("fifo_count", int'(fifo_count), m_q.size());
    chk("evt_valid", int'(evt_valid), int'(m_q.size() != 0));
    chk("pending", int'(pending), int'(mp));
    chk("overflow", int'(overflow), int'(m_ovf));
`ifdef BTN_EVT_DROP_CNT_EN
    chk("drop_count", int'(drop_count), m_drop);
`endif
  endtask

  always @(negedge clk)
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL evt_id: popped id %0d but none expected at %0t", evt_id, $time);
      end else begin
        e = exp_q.pop_front();
        if (int'(evt_id) != e) begin
          failures++;
          $display("FAIL evt_id: got %0d expected %0d at %0t", evt_id, e, $time);
        end
      end
    end

  initial begin
    cyc('0, 0, 1);
    cyc('0, 0, 1);
    cyc(4'b0100, 1, 0);
    repeat (3) cyc('0, 1, 0);
    cyc(4'b1111, 0, 0);
    repeat (5) cyc('0, 0, 0);
    repeat (6) cyc('0, 1, 0);
    repeat (8) cyc(4'b1001, 1, 0);
    repeat (4) cyc('0, 1, 0);
    cyc('0, 0, 1);
    repeat (6) begin
      cyc(4'b0010, 0, 0);
      cyc('0, 0, 0);
    end
    repeat (8) cyc('0, 1, 0);
    cyc('0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(N'(1) << (i % N), bit'(i % 2), 0);
    for (int i = 0; i < 16; i++) cyc('0, bit'(i % 2), 0);
    cyc(4'b0111, 0, 0);
    repeat (3) cyc('0, 0, 0);
    cyc(4'b1000, 1, 1);
    cyc('0, 1, 0);
    repeat (400) begin
      logic [N-1:0] p;
      p = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cyc(p, bit'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
    end
    repeat (10) cyc('0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
